// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: four requesters share one FIFO write port in bursts of up to BURST_LEN words.
// Optional saturating write counter on wr_count is enabled by defining FIFO_WR_ARB_STATS_EN.
//
// state | meaning
// IDLE  | no grant held; round-robin decision made this cycle, no write
// XFER  | grant held by owner; writes while req[owner] and FIFO not full
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              req,
  input  logic [4*DATA_WIDTH-1:0] req_data,
  output logic [3:0]              ack,
  input  logic                    wfull,
  output logic                    winc,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [1:0]              owner,
  output logic                    busy,
  output logic [15:0]             wr_count
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q, last_d;
  logic [7:0] beat_q, beat_d;
  logic [1:0] cand;
  logic [1:0] pick;
  logic       pick_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
      beat_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  // Search starts one past the previous owner so every requester gets a turn.
  always_comb begin
    cand     = 2'd0;
    pick     = 2'd0;
    pick_vld = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!pick_vld && req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    beat_d  = beat_q;
    winc    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d = pick;
          last_d  = pick;
          beat_d  = 8'd0;
          state_d = XFER;
        end
      end
      XFER: begin
        winc = req[owner_q] & ~wfull;
        if (winc) beat_d = beat_q + 8'd1;
        if (!req[owner_q] || (winc && beat_q == LAST_BEAT)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ack = winc ? (4'b0001 << owner_q) : 4'b0000;
  end

  assign wdata = req_data[int'(owner_q) * DATA_WIDTH +: DATA_WIDTH];
  assign owner = owner_q;
  assign busy  = (state_q == XFER);

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] wr_count_q;

  // Saturate rather than wrap so a long run never reports a small count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count_q <= 16'h0000;
    end else if (winc && wr_count_q != 16'hFFFF) begin
      wr_count_q <= wr_count_q + 16'h0001;
    end
  end

  assign wr_count = wr_count_q;
`else
  assign wr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the round-robin burst rules.
module tb_fifo_wr_arbiter;

  localparam int DW  = 8;
  localparam int BL  = 4;
  localparam int BL2 = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req, req2;
  logic [4*DW-1:0] req_data, req_data2;
  logic          wfull, wfull2;
  logic [3:0]    ack, ack2;
  logic          winc, winc2;
  logic [DW-1:0] wdata, wdata2;
  logic [1:0]    owner, owner2;
  logic          busy, busy2;
  logic [15:0]   wr_count, wr_count2;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .wfull(wfull), .winc(winc), .wdata(wdata), .owner(owner), .busy(busy),
    .wr_count(wr_count)
  );

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .BURST_LEN(BL2)) dut_long (
    .clk(clk), .rst(rst), .req(req2), .req_data(req_data2), .ack(ack2),
    .wfull(wfull2), .winc(winc2), .wdata(wdata2), .owner(owner2), .busy(busy2),
    .wr_count(wr_count2)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] obs();
    return {busy, owner, winc, ack};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0; wfull = 1'b0; req2 = 4'b0; wfull2 = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; wfull = 1'b0; req2 = 4'b0; wfull2 = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== 8'b0_00_0_0000) begin
      n_bad++; $display("FAIL reset_state: got %h want %h", obs(), 8'h00);
    end
    n_cmp++;
    if (wr_count !== 16'h0) begin
      n_bad++; $display("FAIL reset_wr_count: got %h want 0000", wr_count);
    end
    cyc();
    cyc();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_hold_busy: got %b want 0", busy);
    end
    rst = 1'b0;
    cyc();
    #1;
    n_cmp++;
    if (obs() !== {1'b1, 2'd0, 1'b1, 4'b0001}) begin
      n_bad++; $display("FAIL reset_first_grant: got %h want %h", obs(), {1'b1, 2'd0, 1'b1, 4'b0001});
    end
  endtask

  task automatic test_single();
    logic [7:0] exp;
    do_reset();
    req = 4'b0001; req_data = 32'($urandom);
    for (int c = 0; c < 10; c++) begin
      #1;
      exp = (c == 0 || c == 5) ? 8'b0_00_0_0000 : {1'b1, 2'd0, 1'b1, 4'b0001};
      n_cmp++;
      if (obs() !== exp) begin
        n_bad++; $display("FAIL single_cycle%0d: got %h want %h", c, obs(), exp);
      end
      cyc();
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp;
    logic [1:0] o;
    do_reset();
    req = 4'b1111; req_data = 32'($urandom);
    for (int g = 0; g < 5; g++) begin
      #1;
      o = (g == 0) ? 2'd0 : 2'((g - 1) % 4);
      exp = {1'b0, o, 1'b0, 4'b0000};
      n_cmp++;
      if (obs() !== exp) begin
        n_bad++; $display("FAIL rr_idle%0d: got %h want %h", g, obs(), exp);
      end
      cyc();
      o = 2'(g % 4);
      for (int b = 0; b < BL; b++) begin
        #1;
        exp = {1'b1, o, 1'b1, 4'(1 << (g % 4))};
        n_cmp++;
        if (obs() !== exp) begin
          n_bad++; $display("FAIL rr_grant%0d_beat%0d: got %h want %h", g, b, obs(), exp);
        end
        n_cmp++;
        if (wdata !== req_data[(g % 4) * DW +: DW]) begin
          n_bad++; $display("FAIL rr_wdata%0d: got %h want %h", g, wdata, req_data[(g % 4) * DW +: DW]);
        end
        cyc();
      end
    end
    req = 4'b0;
  endtask

  task automatic test_wfull_stall();
    do_reset();
    req = 4'b0100; req_data = 32'($urandom);
    cyc();
    for (int b = 0; b < 2; b++) begin
      #1;
      n_cmp++;
      if (obs() !== {1'b1, 2'd2, 1'b1, 4'b0100}) begin
        n_bad++; $display("FAIL stall_pre_write%0d: got %h want %h", b, obs(), {1'b1, 2'd2, 1'b1, 4'b0100});
      end
      cyc();
    end
    wfull = 1'b1;
    for (int s = 0; s < 5; s++) begin
      #1;
      n_cmp++;
      if (obs() !== {1'b1, 2'd2, 1'b0, 4'b0000}) begin
        n_bad++; $display("FAIL stall_hold%0d: got %h want %h", s, obs(), {1'b1, 2'd2, 1'b0, 4'b0000});
      end
      cyc();
    end
    wfull = 1'b0;
    for (int b = 0; b < 2; b++) begin
      #1;
      n_cmp++;
      if (obs() !== {1'b1, 2'd2, 1'b1, 4'b0100}) begin
        n_bad++; $display("FAIL stall_post_write%0d: got %h want %h", b, obs(), {1'b1, 2'd2, 1'b1, 4'b0100});
      end
      cyc();
    end
    #1;
    n_cmp++;
    if (obs() !== {1'b0, 2'd2, 1'b0, 4'b0000}) begin
      n_bad++; $display("FAIL stall_release: got %h want %h", obs(), {1'b0, 2'd2, 1'b0, 4'b0000});
    end
    req = 4'b0;
  endtask

  task automatic test_drop_req();
    do_reset();
    req = 4'b1010; req_data = 32'($urandom);
    cyc();
    #1;
    n_cmp++;
    if (obs() !== {1'b1, 2'd1, 1'b1, 4'b0010}) begin
      n_bad++; $display("FAIL drop_first_write: got %h want %h", obs(), {1'b1, 2'd1, 1'b1, 4'b0010});
    end
    cyc();
    req = 4'b1000;
    #1;
    n_cmp++;
    if (obs() !== {1'b1, 2'd1, 1'b0, 4'b0000}) begin
      n_bad++; $display("FAIL drop_no_write: got %h want %h", obs(), {1'b1, 2'd1, 1'b0, 4'b0000});
    end
    cyc();
    #1;
    n_cmp++;
    if (obs() !== {1'b0, 2'd1, 1'b0, 4'b0000}) begin
      n_bad++; $display("FAIL drop_idle: got %h want %h", obs(), {1'b0, 2'd1, 1'b0, 4'b0000});
    end
    cyc();
    #1;
    n_cmp++;
    if (obs() !== {1'b1, 2'd3, 1'b1, 4'b1000}) begin
      n_bad++; $display("FAIL drop_next_owner: got %h want %h", obs(), {1'b1, 2'd3, 1'b1, 4'b1000});
    end
    req = 4'b0;
  endtask

  task automatic test_reset_midburst();
    do_reset();
    req = 4'b0001; req_data = 32'($urandom);
    cyc();
    cyc();
    cyc();
    #1;
    n_cmp++;
    if (obs() !== {1'b1, 2'd0, 1'b1, 4'b0001}) begin
      n_bad++; $display("FAIL midrst_third_write: got %h want %h", obs(), {1'b1, 2'd0, 1'b1, 4'b0001});
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs() !== 8'b0_00_0_0000) begin
      n_bad++; $display("FAIL midrst_async: got %h want %h", obs(), 8'h00);
    end
    n_cmp++;
    if (wr_count !== 16'h0) begin
      n_bad++; $display("FAIL midrst_wr_count: got %h want 0000", wr_count);
    end
    cyc();
    req = 4'b0110;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== 8'b0_00_0_0000) begin
      n_bad++; $display("FAIL midrst_idle: got %h want %h", obs(), 8'h00);
    end
    cyc();
    #1;
    n_cmp++;
    if (obs() !== {1'b1, 2'd1, 1'b1, 4'b0010}) begin
      n_bad++; $display("FAIL midrst_owner: got %h want %h", obs(), {1'b1, 2'd1, 1'b1, 4'b0010});
    end
    req = 4'b0;
  endtask

  // Transaction-level model: who holds the grant, who held it last, words written in this grant.
  task automatic test_random();
    bit         m_busy = 1'b0;
    int         m_owner = 0;
    int         m_last = 3;
    int         m_beats = 0;
    int         m_writes = 0;
    logic       e_winc;
    logic [7:0] exp;
    logic [15:0] e_cnt;
    do_reset();
    req_data = 32'($urandom);
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      if ($urandom_range(0, 7) == 0) req_data = 32'($urandom);
      wfull = ($urandom_range(0, 4) == 0);
      #1;
      e_winc = m_busy && req[m_owner] && !wfull;
      exp = {m_busy, 2'(m_owner), e_winc, e_winc ? 4'(1 << m_owner) : 4'b0000};
      n_cmp++;
      if (obs() !== exp) begin
        n_bad++; $display("FAIL rand_cycle%0d: got %h want %h (req %b wfull %b)", c, obs(), exp, req, wfull);
      end
      n_cmp++;
      if (wdata !== req_data[m_owner * DW +: DW]) begin
        n_bad++; $display("FAIL rand_wdata%0d: got %h want %h", c, wdata, req_data[m_owner * DW +: DW]);
      end
`ifdef FIFO_WR_ARB_STATS_EN
      e_cnt = (m_writes > 65535) ? 16'hFFFF : 16'(m_writes);
`else
      e_cnt = 16'h0000;
`endif
      n_cmp++;
      if (wr_count !== e_cnt) begin
        n_bad++; $display("FAIL rand_wr_count%0d: got %h want %h", c, wr_count, e_cnt);
      end
      if (!m_busy) begin
        if (req != 4'b0) begin
          for (int k = 1; k <= 4; k++) begin
            int idx = (m_last + k) % 4;
            if (req[idx]) begin
              m_owner = idx;
              break;
            end
          end
          m_last = m_owner;
          m_beats = 0;
          m_busy = 1'b1;
        end
      end else begin
        if (e_winc) begin
          m_beats++;
          m_writes++;
        end
        if (!req[m_owner] || m_beats == BL) m_busy = 1'b0;
      end
      cyc();
    end
    req = 4'b0;
    wfull = 1'b0;
  endtask

  task automatic test_stats();
    int writes = 0;
    logic [15:0] e_cnt;
    do_reset();
    req_data2 = 32'($urandom);
`ifdef FIFO_WR_ARB_STATS_EN
    req2 = 4'b0001;
    for (int c = 0; c < 72000 && writes < 70000; c++) begin
      #1;
      e_cnt = (writes > 65535) ? 16'hFFFF : 16'(writes);
      n_cmp++;
      if (wr_count2 !== e_cnt) begin
        n_bad++; $display("FAIL stats_count_w%0d: got %h want %h", writes, wr_count2, e_cnt);
      end
      if (winc2) writes++;
      cyc();
    end
    n_cmp++;
    if (writes < 70000) begin
      n_bad++; $display("FAIL stats_timeout: got %0d writes want 70000", writes);
    end
    #1;
    n_cmp++;
    if (wr_count2 !== 16'hFFFF) begin
      n_bad++; $display("FAIL stats_saturated: got %h want ffff", wr_count2);
    end
`else
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 15) == 0) req2 = 4'($urandom);
      #1;
      n_cmp++;
      if (wr_count2 !== 16'h0000) begin
        n_bad++; $display("FAIL stats_off_cycle%0d: got %h want 0000", c, wr_count2);
      end
      if (winc2) writes++;
      cyc();
    end
    n_cmp++;
    if (writes == 0) begin
      n_bad++; $display("FAIL stats_off_traffic: got %0d writes want >0", writes);
    end
`endif
    req2 = 4'b0;
  endtask

  initial begin
    rst = 1'b1; req = 4'b0; wfull = 1'b0; req2 = 4'b0; wfull2 = 1'b0;
    req_data = '0; req_data2 = '0;
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_wfull_stall();
    test_drop_req();
    test_reset_midburst();
    test_random();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
